// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: period-mode codes, control/guard/TERC4 symbol tables, popcount.
// The TERC4 table only exists when TMDS_TERC4_EN is defined (HDMI build).
package tmds_pkg;

    typedef enum logic [2:0] {
        TMDS_MODE_CTRL   = 3'd0,
        TMDS_MODE_VIDEO  = 3'd1,
        TMDS_MODE_VGUARD = 3'd2,
        TMDS_MODE_DATA   = 3'd3,
        TMDS_MODE_DGUARD = 3'd4
    } tmds_mode_e;

    // Indexed by {C1,C0}
    localparam logic [9:0] CTRL_TOKEN [4] = '{10'h0AB, 10'h354, 10'h0AA, 10'h355};

    localparam logic [9:0] GUARD_SYM_EVEN = 10'h0CD;
    localparam logic [9:0] GUARD_SYM_ODD  = 10'h332;

`ifdef TMDS_TERC4_EN
    localparam logic [9:0] TERC4_TABLE [16] = '{
        10'h0E5, 10'h319, 10'h09D, 10'h11D, 10'h23A, 10'h1E2, 10'h1C6, 10'h0F2,
        10'h0CD, 10'h272, 10'h0E6, 10'h18D, 10'h1C5, 10'h239, 10'h31A, 10'h30D
    };
`endif

    function automatic logic [3:0] n1_count(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/tmds_lane_enc.sv
// One TMDS lane: transition-minimise, DC-balance with running disparity, token mux.
// TMDS_TERC4_EN adds DATA/DGUARD TERC4 symbols; otherwise aux is ignored.
module tmds_lane_enc
    import tmds_pkg::*;
#(
    parameter int LANE = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  tmds_mode_e mode_s2,
    input  tmds_mode_e mode_s4,
    input  logic [7:0] d,
    input  logic [1:0] c,
    input  logic [3:0] aux,
    output logic [9:0] q
);

    logic [7:0]        d_s1_reg, d_s2_reg;
    logic [1:0]        c_s1_reg, c_s2_reg;
    logic [3:0]        n1d_s2_reg;
    logic [8:0]        qm_s3_reg, qm_s4_reg;
    logic [9:0]        token_s3_reg, token_s4_reg;
    logic signed [5:0] diff_s4_reg;
    logic [9:0]        q_reg;
    logic signed [5:0] cnt_reg;

    logic              xnor_sel;
    logic [8:0]        qm_next;
    logic [9:0]        token_next;
    logic signed [5:0] diff_next;
    logic              m8;
    logic [9:0]        q_next;
    logic signed [5:0] cnt_next;

`ifdef TMDS_TERC4_EN
    logic [3:0] aux_s1_reg, aux_s2_reg;

    always_ff @(posedge clk) begin
        aux_s1_reg <= aux;
        aux_s2_reg <= aux_s1_reg;
    end
`else
    logic aux_unused;
    assign aux_unused = ^aux;
`endif

    // Data stages run freely; only the final stage is qualified by the valid pipeline.
    always_ff @(posedge clk) begin
        d_s1_reg     <= d;
        c_s1_reg     <= c;
        d_s2_reg     <= d_s1_reg;
        c_s2_reg     <= c_s1_reg;
        n1d_s2_reg   <= n1_count(d_s1_reg);
        qm_s3_reg    <= qm_next;
        token_s3_reg <= token_next;
        qm_s4_reg    <= qm_s3_reg;
        diff_s4_reg  <= diff_next;
        token_s4_reg <= token_s3_reg;
    end

    always_comb begin
        xnor_sel   = (n1d_s2_reg > 4'd4) || ((n1d_s2_reg == 4'd4) && !d_s2_reg[0]);
        qm_next    = '0;
        qm_next[0] = d_s2_reg[0];
        for (int i = 1; i < 8; i++) begin
            qm_next[i] = xnor_sel ? ~(qm_next[i-1] ^ d_s2_reg[i]) : (qm_next[i-1] ^ d_s2_reg[i]);
        end
        qm_next[8] = ~xnor_sel;
    end

    always_comb begin
        token_next = CTRL_TOKEN[c_s2_reg];
        case (mode_s2)
            TMDS_MODE_VGUARD: token_next = (LANE % 2 == 0) ? GUARD_SYM_EVEN : GUARD_SYM_ODD;
`ifdef TMDS_TERC4_EN
            TMDS_MODE_DATA:   token_next = TERC4_TABLE[aux_s2_reg];
            TMDS_MODE_DGUARD: token_next = (LANE == 0) ? TERC4_TABLE[{2'b11, c_s2_reg}] : GUARD_SYM_ODD;
`endif
            default: ;
        endcase
    end

    // N1 - N0 of q_m[7:0], i.e. 2*N1 - 8
    assign diff_next = $signed({1'b0, n1_count(qm_s3_reg[7:0]), 1'b0}) - 6'sd8;

    assign m8 = qm_s4_reg[8];

    always_comb begin
        q_next   = token_s4_reg;
        cnt_next = '0;
        if (mode_s4 == TMDS_MODE_VIDEO) begin
            if ((cnt_reg == 0) || (diff_s4_reg == 0)) begin
                q_next   = {~m8, m8, m8 ? qm_s4_reg[7:0] : ~qm_s4_reg[7:0]};
                cnt_next = m8 ? (cnt_reg + diff_s4_reg) : (cnt_reg - diff_s4_reg);
            end else if (((cnt_reg > 0) && (diff_s4_reg > 0)) ||
                         ((cnt_reg < 0) && (diff_s4_reg < 0))) begin
                q_next   = {1'b1, m8, ~qm_s4_reg[7:0]};
                cnt_next = cnt_reg + (m8 ? 6'sd2 : 6'sd0) - diff_s4_reg;
            end else begin
                q_next   = {1'b0, m8, qm_s4_reg[7:0]};
                cnt_next = cnt_reg - (m8 ? 6'sd0 : 6'sd2) + diff_s4_reg;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_reg   <= '0;
            cnt_reg <= '0;
        end else if (load) begin
            q_reg   <= q_next;
            cnt_reg <= cnt_next;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/tmds_encoder_mc.sv
// Multi-channel TMDS encoder: shared strobe/mode pipeline plus one tmds_lane_enc per lane.
// Define TMDS_TERC4_EN for the HDMI build (DATA/DGUARD); otherwise modes 3/4 encode as CTRL.
module tmds_encoder_mc
    import tmds_pkg::*;
#(
    parameter int CHANNELS = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    pixel_stb,
    input  logic [2:0]              mode,
    input  logic [8*CHANNELS-1:0]   d,
    input  logic [2*CHANNELS-1:0]   c,
    input  logic [4*CHANNELS-1:0]   aux,
    output logic [10*CHANNELS-1:0]  q_out,
    output logic                    q_stb
);

    logic [3:0] vld_reg;
    logic       q_stb_reg;
    tmds_mode_e mode_s1_reg, mode_s2_reg, mode_s3_reg, mode_s4_reg;

    function automatic tmds_mode_e mode_decode(input logic [2:0] m);
        case (m)
            3'd1:    return TMDS_MODE_VIDEO;
            3'd2:    return TMDS_MODE_VGUARD;
`ifdef TMDS_TERC4_EN
            3'd3:    return TMDS_MODE_DATA;
            3'd4:    return TMDS_MODE_DGUARD;
`endif
            default: return TMDS_MODE_CTRL;
        endcase
    endfunction

    // Reset clears the valids, so in-flight samples never reach the lane outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_reg   <= '0;
            q_stb_reg <= 1'b0;
        end else begin
            vld_reg   <= {vld_reg[2:0], pixel_stb};
            q_stb_reg <= vld_reg[3];
        end
    end

    always_ff @(posedge clk) begin
        mode_s1_reg <= mode_decode(mode);
        mode_s2_reg <= mode_s1_reg;
        mode_s3_reg <= mode_s2_reg;
        mode_s4_reg <= mode_s3_reg;
    end

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : gen_lane
            tmds_lane_enc #(
                .LANE (gi)
            ) u_lane (
                .clk     (clk),
                .reset   (reset),
                .load    (vld_reg[3]),
                .mode_s2 (mode_s2_reg),
                .mode_s4 (mode_s4_reg),
                .d       (d[8*gi +: 8]),
                .c       (c[2*gi +: 2]),
                .aux     (aux[4*gi +: 4]),
                .q       (q_out[10*gi +: 10])
            );
        end
    endgenerate

    assign q_stb = q_stb_reg;

endmodule
